// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and data bundle for the serial magnitude comparator.
interface serial_magnitude_comparator_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  Start_In;
  logic [DATA_WIDTH-1:0] Data_A_In;
  logic [DATA_WIDTH-1:0] Data_B_In;
  logic                  Busy_Out;
  logic                  Valid_Out;
  logic                  A_Less_Than_B_Out;
  logic                  A_Equal_To_B_Out;
  logic                  A_Greater_Than_B_Out;

  modport master (
    output Start_In, Data_A_In, Data_B_In,
    input  Busy_Out, Valid_Out, A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out
  );

  modport slave (
    input  Start_In, Data_A_In, Data_B_In,
    output Busy_Out, Valid_Out, A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial N-bit magnitude comparator: operands latched on start, scanned
// MSB-first one bit per clock; the first differing bit decides the result.
module serial_magnitude_comparator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          SIGNED     = 1'b0,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input logic                         Clock_In,
  input logic                         Reset_In,
  serial_magnitude_comparator_if.slave Cmp
);

  localparam int unsigned IW = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [IW-1:0]         idx_q;
  logic                  decided_q;
  logic                  lt_q;
  logic                  gt_q;
  logic                  busy_q;
  logic                  valid_q;
  logic                  res_lt_q;
  logic                  res_eq_q;
  logic                  res_gt_q;

  logic                  a_bit;
  logic                  b_bit;
  logic                  bit_diff;
  logic                  bit_lt;
  logic                  lt_d;
  logic                  gt_d;
  logic                  decided_d;
  logic                  finish_d;

  // 1-bit compare stage on the currently indexed bit, plus sticky decision
  always_comb begin
    a_bit     = a_q[idx_q];
    b_bit     = b_q[idx_q];
    bit_diff  = a_bit ^ b_bit;
    // Sign bit of two's complement operands has inverted weight
    if (SIGNED && (idx_q == IW'(DATA_WIDTH - 1))) begin
      bit_lt = a_bit & ~b_bit;
    end else begin
      bit_lt = ~a_bit & b_bit;
    end
    lt_d      = decided_q ? lt_q : (bit_diff & bit_lt);
    gt_d      = decided_q ? gt_q : (bit_diff & ~bit_lt);
    decided_d = decided_q | bit_diff;
    finish_d  = (EARLY_EXIT && bit_diff) || (idx_q == '0);
  end

  // Control FSM with registered busy/valid/result outputs
  always_ff @(posedge Clock_In) begin
    if (!Reset_In) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      res_lt_q  <= 1'b0;
      res_eq_q  <= 1'b0;
      res_gt_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Cmp.Start_In) begin
            a_q       <= Cmp.Data_A_In;
            b_q       <= Cmp.Data_B_In;
            idx_q     <= IW'(DATA_WIDTH - 1);
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= COMPARE;
          end
        end
        COMPARE: begin
          lt_q      <= lt_d;
          gt_q      <= gt_d;
          decided_q <= decided_d;
          if (finish_d) begin
            res_lt_q <= lt_d;
            res_gt_q <= gt_d;
            res_eq_q <= ~decided_d;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Cmp.Busy_Out             = busy_q;
  assign Cmp.Valid_Out            = valid_q;
  assign Cmp.A_Less_Than_B_Out    = res_lt_q;
  assign Cmp.A_Equal_To_B_Out     = res_eq_q;
  assign Cmp.A_Greater_Than_B_Out = res_gt_q;

endmodule
